// File: rtl/ducks_pkg.sv
// Shared types and screen constants for the duck scheduler and sprite drawers.
package ducks_pkg;
    typedef enum logic [1:0] {
        SLOT_FREE = 2'd0,
        SLOT_FLY  = 2'd1,
        SLOT_FALL = 2'd2
    } slot_state_t;

    typedef enum logic [1:0] {
        CTRL_WAIT   = 2'd0,
        CTRL_UPDATE = 2'd1,
        CTRL_SPAWN  = 2'd2
    } ctrl_state_t;

    localparam int SPRITE_W = 46;
    localparam int SPRITE_H = 40;
    localparam int SCREEN_W = 640;
    // Top of the spawn band; the random offset adds 0..127 on top.
    localparam int SPAWN_Y0 = 40;
    localparam logic [7:0] LFSR_SEED = 8'hA5;
endpackage

// File: rtl/duck_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) used to pick spawn heights.
module duck_lfsr
    import ducks_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    output logic [6:0] rnd
);
    logic [7:0] state;

    // Shift left, feedback into bit 0; the non-zero seed keeps it off the lock-up state.
    always_ff @(posedge clk) begin
        if (reset)
            state <= LFSR_SEED;
        else if (en)
            state <= {state[6:0], state[7] ^ state[5] ^ state[4] ^ state[3]};
    end

    assign rnd = state[6:0];
endmodule

// File: rtl/duck_flight_scheduler.sv
// Per-frame duck sequencer: spawns, moves, retires ducks and keeps score.
module duck_flight_scheduler
    import ducks_pkg::*;
#(
    parameter int NUM_DUCKS    = 4,
    parameter int SPRITE_W     = ducks_pkg::SPRITE_W,
    parameter int SCREEN_W     = ducks_pkg::SCREEN_W,
    parameter int FRAME_LINE   = 480,
    parameter int FLOOR_Y      = 440,
    parameter int SPEED_X      = 2,
    parameter int FALL_SPEED   = 4,
    parameter int BOB_FRAMES   = 30,
    parameter int SPAWN_FRAMES = 60,
    parameter int WAVE_SIZE    = 10,
    localparam int IDXW = (NUM_DUCKS > 1) ? $clog2(NUM_DUCKS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [9:0]             hcount,
    input  logic [9:0]             vcount,
    input  logic                   hit_valid,
    input  logic [IDXW-1:0]        hit_slot,
    output logic [11*NUM_DUCKS-1:0] pos_x,
    output logic [10*NUM_DUCKS-1:0] pos_y,
    output logic [NUM_DUCKS-1:0]   active,
    output logic [NUM_DUCKS-1:0]   falling,
    output logic [7:0]             score,
    output logic [7:0]             escaped,
    output logic                   wave_done
);
    localparam int BOBW = $clog2(BOB_FRAMES + 1);
    localparam int SPNW = $clog2(SPAWN_FRAMES + 1);
    localparam int WAVW = $clog2(WAVE_SIZE + 1);
    localparam logic signed [10:0] PARK_X = 11'(SCREEN_W);
    localparam logic signed [10:0] ESC_X  = 11'(-SPRITE_W);
    localparam logic signed [10:0] STEP_X = 11'(SPEED_X);
    localparam logic [9:0] FLOOR  = 10'(FLOOR_Y);
    localparam logic [9:0] FALL_D = 10'(FALL_SPEED);

    slot_state_t        st     [NUM_DUCKS];
    logic signed [10:0] px     [NUM_DUCKS];
    logic [9:0]         py     [NUM_DUCKS];
    logic               bob_up [NUM_DUCKS];   // 1: y decreasing
    logic [BOBW-1:0]    bob    [NUM_DUCKS];

    ctrl_state_t     cs, cs_nx;
    logic [IDXW-1:0] idx;
    logic            tick;
    logic [SPNW-1:0] spn_cnt, spn_next;
    logic [WAVW-1:0] spawned;
    logic [6:0]      rnd;
    logic            free_any, all_free, spawn_go, hit_ok, esc_evt;
    logic [IDXW-1:0] free_idx;

    duck_lfsr u_lfsr (.clk(clk), .reset(reset), .en(1'b1), .rnd(rnd));

    // Control sequencing: one slot per clock after the frame tick, then one spawn cycle.
    always_comb begin
        cs_nx = cs;
        case (cs)
            CTRL_WAIT:   if (tick) cs_nx = CTRL_UPDATE;
            CTRL_UPDATE: if (idx == IDXW'(NUM_DUCKS - 1)) cs_nx = CTRL_SPAWN;
            CTRL_SPAWN:  cs_nx = CTRL_WAIT;
            default:     cs_nx = CTRL_WAIT;
        endcase
    end

    // Lowest free slot, spawn decision, hit acceptance and escape detection.
    always_comb begin
        free_any = 1'b0;
        all_free = 1'b1;
        free_idx = '0;
        for (int i = NUM_DUCKS - 1; i >= 0; i--) begin
            if (st[i] == SLOT_FREE) begin
                free_any = 1'b1;
                free_idx = IDXW'(i);
            end else begin
                all_free = 1'b0;
            end
        end
        spn_next = (spn_cnt == SPNW'(SPAWN_FRAMES)) ? spn_cnt : spn_cnt + SPNW'(1);
        spawn_go = (spn_next == SPNW'(SPAWN_FRAMES)) && (spawned < WAVW'(WAVE_SIZE)) && free_any;
        hit_ok   = hit_valid && (int'(hit_slot) < NUM_DUCKS) && (st[hit_slot] == SLOT_FLY);
        // A hit on the slot being updated wins, so it cannot also escape.
        esc_evt  = (cs == CTRL_UPDATE) && (st[idx] == SLOT_FLY) && (px[idx] - STEP_X < ESC_X)
                   && !(hit_ok && hit_slot == idx);
    end

    // Control registers, frame tick and counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            cs        <= CTRL_WAIT;
            idx       <= '0;
            tick      <= 1'b0;
            spn_cnt   <= '0;
            spawned   <= '0;
            score     <= '0;
            escaped   <= '0;
            wave_done <= 1'b0;
        end else begin
            cs   <= cs_nx;
            tick <= (hcount == 10'd0) && (vcount == 10'(FRAME_LINE));
            if (cs == CTRL_UPDATE && idx != IDXW'(NUM_DUCKS - 1))
                idx <= idx + IDXW'(1);
            else
                idx <= '0;
            if (hit_ok && score != 8'hFF)
                score <= score + 8'd1;
            if (esc_evt && escaped != 8'hFF)
                escaped <= escaped + 8'd1;
            if (cs == CTRL_SPAWN) begin
                if (spawn_go) begin
                    spn_cnt <= '0;
                    spawned <= spawned + WAVW'(1);
                end else begin
                    spn_cnt <= spn_next;
                end
                if (spawned == WAVW'(WAVE_SIZE) && all_free)
                    wave_done <= 1'b1;
            end
        end
    end

    // Slot state: hit has priority, then the per-frame move, then spawning into a free slot.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_DUCKS; i++) begin
            if (reset) begin
                st[i]     <= SLOT_FREE;
                px[i]     <= PARK_X;
                py[i]     <= '0;
                bob_up[i] <= 1'b0;
                bob[i]    <= '0;
            end else if (hit_ok && hit_slot == IDXW'(i)) begin
                st[i] <= SLOT_FALL;
            end else if (cs == CTRL_UPDATE && idx == IDXW'(i)) begin
                case (st[i])
                    SLOT_FLY: begin
                        py[i] <= bob_up[i] ? py[i] - 10'd1 : py[i] + 10'd1;
                        if (bob[i] == BOBW'(BOB_FRAMES - 1)) begin
                            bob[i]    <= '0;
                            bob_up[i] <= ~bob_up[i];
                        end else begin
                            bob[i] <= bob[i] + BOBW'(1);
                        end
                        if (px[i] - STEP_X < ESC_X) begin
                            st[i] <= SLOT_FREE;
                            px[i] <= PARK_X;
                        end else begin
                            px[i] <= px[i] - STEP_X;
                        end
                    end
                    SLOT_FALL: begin
                        if (py[i] + FALL_D >= FLOOR) begin
                            st[i] <= SLOT_FREE;
                            py[i] <= FLOOR;
                            px[i] <= PARK_X;
                        end else begin
                            py[i] <= py[i] + FALL_D;
                        end
                    end
                    default: px[i] <= PARK_X;
                endcase
            end else if (cs == CTRL_SPAWN && spawn_go && free_idx == IDXW'(i)) begin
                st[i]     <= SLOT_FLY;
                px[i]     <= PARK_X;
                py[i]     <= 10'(SPAWN_Y0) + 10'(rnd);
                bob_up[i] <= 1'b0;
                bob[i]    <= '0;
            end
        end
    end

    for (genvar g = 0; g < NUM_DUCKS; g++) begin : g_out
        assign pos_x[11*g +: 11] = px[g];
        assign pos_y[10*g +: 10] = py[g];
        assign active[g]         = (st[g] != SLOT_FREE);
        assign falling[g]        = (st[g] == SLOT_FALL);
    end
endmodule

// File: tb/tb_duck_flight_scheduler.sv
// Directed scoreboard bench for duck_flight_scheduler (default and fast-spawn instances).
module tb_duck_flight_scheduler;
    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, rst2, hv, hv2;
    logic [1:0] hs, hs2;
    logic [9:0] hcount, vcount;
    logic [11*N-1:0] px, px2;
    logic [10*N-1:0] py, py2;
    logic [N-1:0] act, act2, fal, fal2;
    logic [7:0] sc, sc2, es, es2;
    logic wd, wd2;

    duck_flight_scheduler dut (
        .clk(clk), .reset(rst), .hcount(hcount), .vcount(vcount),
        .hit_valid(hv), .hit_slot(hs), .pos_x(px), .pos_y(py),
        .active(act), .falling(fal), .score(sc), .escaped(es), .wave_done(wd));

    duck_flight_scheduler #(.SPAWN_FRAMES(1), .WAVE_SIZE(10)) dut2 (
        .clk(clk), .reset(rst2), .hcount(hcount), .vcount(vcount),
        .hit_valid(hv2), .hit_slot(hs2), .pos_x(px2), .pos_y(py2),
        .active(act2), .falling(fal2), .score(sc2), .escaped(es2), .wave_done(wd2));

    typedef enum int {S_ACTV, S_FALV, S_ACT, S_FAL, S_X, S_Y, S_YRNG, S_SCORE, S_ESC, S_WD} sel_t;
    typedef struct {
        string tag;
        int    d;
        sel_t  sel;
        int    slot;
        int    exp;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    function automatic int obs(input int d, input sel_t sel, input int slot);
        logic [11*N-1:0] x;
        logic [10*N-1:0] y;
        logic [N-1:0] a, f;
        x = d ? px2 : px;   y = d ? py2 : py;
        a = d ? act2 : act; f = d ? fal2 : fal;
        case (sel)
            S_ACTV:  return int'(a);
            S_FALV:  return int'(f);
            S_ACT:   return int'(a[slot]);
            S_FAL:   return int'(f[slot]);
            S_X:     return int'($signed(x[11*slot +: 11]));
            S_Y:     return int'(y[10*slot +: 10]);
            S_YRNG:  return int'(y[10*slot +: 10] >= 10'd40 && y[10*slot +: 10] <= 10'd167);
            S_SCORE: return int'(d ? sc2 : sc);
            S_ESC:   return int'(d ? es2 : es);
            default: return int'(d ? wd2 : wd);
        endcase
    endfunction

    // x of a duck spawned in frame s, observed after frame f
    function automatic int xm(input int f, input int s);
        return 640 - 2 * (f - s);
    endfunction

    task automatic expect_(input string tag, input int d, input sel_t sel, input int slot, input int exp);
        sb.push_back('{tag, d, sel, slot, exp});
    endtask

    task automatic drain();
        exp_t e;
        int o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs(e.d, e.sel, e.slot);
            checks++;
            assert (o === e.exp) else begin
                errors++;
                $error("FAIL %s: observed %0d expected %0d", e.tag, o, e.exp);
            end
        end
    endtask

    task automatic expect_reset(input int d);
        for (int i = 0; i < N; i++) begin
            expect_("rst_x", d, S_X, i, 640);
            expect_("rst_y", d, S_Y, i, 0);
        end
        expect_("rst_act", d, S_ACTV, 0, 0);
        expect_("rst_fal", d, S_FALV, 0, 0);
        expect_("rst_score", d, S_SCORE, 0, 0);
        expect_("rst_esc", d, S_ESC, 0, 0);
        expect_("rst_wd", d, S_WD, 0, 0);
    endtask

    task automatic frame();
        @(negedge clk); hcount = 10'd0; vcount = 10'd480;
        @(negedge clk); hcount = 10'd1; vcount = 10'd0;
        repeat (N + 3) @(negedge clk);
    endtask

    // Frame whose hit pulse lands on the clock that updates 'slot'.
    task automatic frame_hit_on_update(input int slot);
        @(negedge clk); hcount = 10'd0; vcount = 10'd480;
        @(negedge clk); hcount = 10'd1; vcount = 10'd0;
        repeat (slot + 1) @(negedge clk);
        hv = 1'b1; hs = 2'(slot);
        @(negedge clk); hv = 1'b0;
        repeat (N + 2) @(negedge clk);
    endtask

    task automatic hit(input int d, input int slot);
        @(negedge clk);
        if (d != 0) begin hv2 = 1'b1; hs2 = 2'(slot); end
        else begin hv = 1'b1; hs = 2'(slot); end
        @(negedge clk); hv = 1'b0; hv2 = 1'b0;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int fc, y0, k, xpre, spawns, hits;
        bit landed, done;
        rst = 1'b1; rst2 = 1'b1; hv = 1'b0; hv2 = 1'b0; hs = '0; hs2 = '0;
        hcount = 10'd1; vcount = 10'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // ---- default instance: spawn timing, flight, escape ----
        expect_reset(0); drain();
        frame();
        expect_("f1_act", 0, S_ACTV, 0, 0); expect_("f1_x0", 0, S_X, 0, 640);
        expect_("f1_score", 0, S_SCORE, 0, 0); drain();
        repeat (59) frame();
        expect_("f60_act", 0, S_ACTV, 0, 1); expect_("f60_x0", 0, S_X, 0, xm(60, 60));
        expect_("f60_yrng", 0, S_YRNG, 0, 1); expect_("f60_fal", 0, S_FALV, 0, 0); drain();
        repeat (10) frame();
        expect_("f70_x0", 0, S_X, 0, xm(70, 60)); drain();
        repeat (333) frame();
        expect_("f403_x0", 0, S_X, 0, xm(403, 60)); expect_("f403_act", 0, S_ACTV, 0, 15);
        expect_("f403_x1", 0, S_X, 1, xm(403, 120)); expect_("f403_esc", 0, S_ESC, 0, 0); drain();
        frame();
        expect_("f404_esc", 0, S_ESC, 0, 1); expect_("f404_respawn_x0", 0, S_X, 0, 640);
        expect_("f404_act", 0, S_ACTV, 0, 15); expect_("f404_x3", 0, S_X, 3, xm(404, 240)); drain();

        // ---- default instance after reset: hit, fall, hit-on-update ----
        rst = 1'b1; repeat (2) @(negedge clk); rst = 1'b0;
        fc = 0;
        repeat (60) begin frame(); fc++; end
        expect_("b_spawn_act", 0, S_ACTV, 0, 1); drain();
        hit(0, 0);
        expect_("hit_fal", 0, S_FALV, 0, 1); expect_("hit_score", 0, S_SCORE, 0, 1);
        expect_("hit_esc", 0, S_ESC, 0, 0); drain();
        hit(0, 0);
        expect_("rehit_score", 0, S_SCORE, 0, 1); expect_("rehit_fal", 0, S_FALV, 0, 1); drain();
        y0 = obs(0, S_Y, 0);
        k = 0; landed = 1'b0;
        while (!landed && k < 120) begin
            frame(); fc++; k++;
            if (y0 + 4 * k < 440) begin
                expect_("fall_fal0", 0, S_FAL, 0, 1); expect_("fall_y0", 0, S_Y, 0, y0 + 4 * k);
            end else begin
                expect_("land_act0", 0, S_ACT, 0, 0); expect_("land_y0", 0, S_Y, 0, 440);
                expect_("land_x0", 0, S_X, 0, 640);
                landed = 1'b1;
            end
            drain();
        end
        while (fc < 125) begin frame(); fc++; end
        xpre = xm(fc, 120);
        frame_hit_on_update(1); fc++;
        expect_("upd_hit_fal1", 0, S_FAL, 1, 1); expect_("upd_hit_x1", 0, S_X, 1, xpre);
        expect_("upd_hit_score", 0, S_SCORE, 0, 2); drain();
        frame(); fc++;
        expect_("fall_x1_held", 0, S_X, 1, xpre); drain();

        // ---- fast-spawn instance: fill, defer, full wave ----
        rst2 = 1'b0;
        for (int s = 1; s <= N; s++) begin
            frame();
            expect_("fill_act", 1, S_ACTV, 0, (1 << s) - 1);
            expect_("fill_x", 1, S_X, s - 1, 640); drain();
        end
        frame();
        expect_("defer_act", 1, S_ACTV, 0, 15); expect_("defer_x0", 1, S_X, 0, 632); drain();
        for (int i = 0; i < N; i++) hit(1, i);
        expect_("hit4_score", 1, S_SCORE, 0, 4); expect_("hit4_fal", 1, S_FALV, 0, 15); drain();
        spawns = N; hits = N; done = 1'b0;
        for (int fr = 0; fr < 600 && !done; fr++) begin
            frame();
            for (int i = 0; i < N; i++) begin
                if (act2[i] && !fal2[i]) begin
                    spawns++;
                    expect_("respawn_x", 1, S_X, i, 640);
                    drain();
                    hit(1, i); hits++;
                end
            end
            expect_("wave_score", 1, S_SCORE, 0, hits);
            if (act2 != '0) expect_("wave_not_done", 1, S_WD, 0, 0);
            drain();
            done = wd2;
        end
        expect_("wave_done", 1, S_WD, 0, 1); expect_("wave_score_final", 1, S_SCORE, 0, 10);
        expect_("wave_act", 1, S_ACTV, 0, 0); expect_("wave_esc", 1, S_ESC, 0, 0); drain();
        checks++;
        assert (spawns == 10) else begin
            errors++;
            $error("FAIL wave_spawns: observed %0d expected %0d", spawns, 10);
        end
        repeat (2) frame();
        expect_("wave_sticky", 1, S_WD, 0, 1); drain();

        // reset asserted while the pass is updating slot 0
        @(negedge clk); hcount = 10'd0; vcount = 10'd480;
        @(negedge clk); hcount = 10'd1; vcount = 10'd0;
        @(negedge clk); rst2 = 1'b1;
        @(negedge clk); rst2 = 1'b0;
        expect_reset(1); drain();
        frame();
        expect_("post_rst_act", 1, S_ACTV, 0, 1); expect_("post_rst_x0", 1, S_X, 0, 640); drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
